fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences the instruction fetch unit: owns the PC, drives it to the combinational
//  instruction memory (ins = mem[pc], word-addressed), and buffers {pc, ins} pairs in a
//  small queue toward decode with a valid/ready handshake. Handles start, branch/jump
//  redirect with queue flush, and backpressure. Sits between the fetch memory and decode.
// PARAMETERS
//  ADDR_W    8             PC index width. PC counts modulo 2^ADDR_W; pc[31:ADDR_W] is always 0.
//  QDEPTH    4             Queue entries. Power of 2, >= 2.
//  RESET_PC  32'd0         PC value loaded at reset. Low ADDR_W bits only.
//  HALT_WORD 32'hFFFFFFFF  Halt encoding. Used only with FETCH_HALT_EN.
// PORTS
//  clk          in   1   clock, all state on posedge
//  rstd         in   1   reset, synchronous, active-high
//  start        in   1   begin fetching (IDLE -> RUN)
//  redirect     in   1   load new PC and flush queue
//  redirect_pc  in   32  new PC, truncated to low ADDR_W bits
//  pc           out  32  current fetch address, to instruction memory
//  ins          in   32  instruction at pc, same cycle (combinational memory)
//  out_valid    out  1   queue head valid
//  out_ready    in   1   decode accepts head
//  out_ins      out  32  head instruction (0 when empty)
//  out_pc       out  32  head PC (0 when empty)
//  busy         out  1   state != IDLE
//  halted       out  1   state == HALT
// BEHAVIOUR
//  - Reset (rstd=1 at edge, overrides all inputs): pc=RESET_PC, queue empty, out_valid=0,
//    out_ins=0, out_pc=0, state=IDLE, busy=0, halted=0.
//  - States: IDLE, RUN, HALT. IDLE: start=1 -> RUN. start outside IDLE is ignored.
//  - RUN push: at each edge where count<QDEPTH or a pop occurs, push {pc, ins} and set
//    pc <= (pc+1) mod 2^ADDR_W. Queue full with no pop: no push, pc holds.
//  - Pop: out_valid & out_ready at edge. Push and pop in the same cycle on a full queue
//    are both allowed; count unchanged.
//  - out_valid = (count != 0); out_ins and out_pc show the head entry. FIFO order.
//  - Latency: start sampled at edge k; first push at edge k+1; out_valid=1 after k+1.
//  - Wrap: pc = 2^ADDR_W-1 is followed by pc = 0; no gap, no stall.
//  - Redirect (any state, priority over push/start): pc <= redirect_pc[ADDR_W-1:0],
//    queue flushed (count=0), no push that edge. A pop in the same cycle is a completed
//    transfer of the old head. IDLE stays IDLE; RUN and HALT go to RUN.
//  - Any queue state at rstd: queue contents are discarded, nothing is delivered.
// CONFIGURATION
//  FETCH_HALT_EN defined: in RUN, a pushed ins == HALT_WORD is queued normally, pc holds
//    at the halt address, and state -> HALT. No pushes in HALT; queue still drains;
//    halted=1. Only redirect or rstd leaves HALT.
//  FETCH_HALT_EN undefined: HALT_WORD is an ordinary instruction, HALT is unreachable,
//    halted is tied to 0.
// TESTING
//  Memory word i = 100+i, RESET_PC=0, ADDR_W=8, QDEPTH=4 unless stated.
//  1 Reset, start at edge k, out_ready=1 -> out_valid=1 after k+1; out_pc 0,1,2,...;
//    out_ins 100,101,...; one transfer per cycle.
//  2 out_ready=0 for 10 cycles after start -> count=4, pc holds at 4; then out_ready=1 ->
//    out_pc 0,1,2,3,4,5 with no gap or duplicate.
//  3 redirect_pc=254 in RUN -> out_pc 254,255,0,1; out_ins 354,355,100,101.
//  4 3 entries queued, out_ready=0, redirect_pc=0x10 -> next out_valid entry has out_pc=0x10
//    and out_ins=116; stale entries never appear.
//  5 rstd=1 for one cycle mid-RUN -> after that edge out_valid=0, pc=0, busy=0, state IDLE;
//    restart delivers from out_pc=0.
//  6 FETCH_HALT_EN, word 5=HALT_WORD -> out_pc 0..5 delivered, halted=1, pc=5 held,
//    no out_pc 6; redirect_pc=0 -> halted=0, delivery resumes at 0.
//    Without the macro -> word 5 passes, out_pc 6 follows, halted=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-unit bus: memory address/data, decode-side valid/ready queue head, and control/status.
// The master modport is the fetch controller; the slave modport is the surrounding system.
interface fetch_ctrl_if;
    logic        start;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        busy;
    logic        halted;

    modport master (
        input  start, redirect, redirect_pc, ins, out_ready,
        output pc, out_valid, out_ins, out_pc, busy, halted
    );

    modport slave (
        output start, redirect, redirect_pc, ins, out_ready,
        input  pc, out_valid, out_ins, out_pc, busy, halted
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, queues {pc, ins} pairs toward decode.
// Optional halt-instruction detection is enabled by defining FETCH_HALT_EN.
module fetch_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned QDEPTH    = 4,
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic          clk,
    input logic          rstd,
    fetch_ctrl_if.master bus
);
    localparam int unsigned    PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0] FULL  = QDEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] q_pc  [QDEPTH];
    logic [31:0]       q_ins [QDEPTH];

    logic pop;
    logic push;
    logic halt_hit;
    logic unused_bits;

`ifdef FETCH_HALT_EN
    assign halt_hit   = (bus.ins == HALT_WORD);
    assign bus.halted = (state == S_HALT);
`else
    assign halt_hit   = 1'b0;
    assign bus.halted = 1'b0;
`endif

    assign unused_bits = ^{bus.redirect_pc[31:ADDR_W], HALT_WORD};

    assign pop  = bus.out_valid && bus.out_ready;
    assign push = (state == S_RUN) && !bus.redirect && ((count != FULL) || pop);

    assign bus.pc        = {{(32-ADDR_W){1'b0}}, pc_q};
    assign bus.out_valid = (count != '0);
    assign bus.out_ins   = (count != '0) ? q_ins[head] : '0;
    assign bus.out_pc    = (count != '0) ? {{(32-ADDR_W){1'b0}}, q_pc[head]} : '0;
    assign bus.busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rstd) begin
            state <= S_IDLE;
            pc_q  <= RESET_PC[ADDR_W-1:0];
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.redirect) begin
            // Redirect wins over push/start; a same-cycle pop is simply absorbed by the flush.
            pc_q  <= bus.redirect_pc[ADDR_W-1:0];
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (state != S_IDLE) begin
                state <= S_RUN;
            end
        end else begin
            if (push) begin
                q_pc[tail]  <= pc_q;
                q_ins[tail] <= bus.ins;
                tail        <= tail + 1'b1;
                if (halt_hit) begin
                    state <= S_HALT;
                end else begin
                    pc_q <= pc_q + 1'b1;
                end
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (state == S_IDLE && bus.start) begin
                state <= S_RUN;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-level reference model, directed scenarios, random traffic.
// Honours FETCH_HALT_EN the same way the design does.
module tb_fetch_ctrl;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic rstd;
    bit   halt_plant = 1'b0;
    bit   checking = 1'b0;
    int   checks = 0;
    int   passes = 0;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_halt;
    logic [31:0] log_pc[$];
    logic [31:0] log_ins[$];

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .ADDR_W   (8),
        .QDEPTH   (4),
        .RESET_PC (32'd0),
        .HALT_WORD(HALT)
    ) dut (
        .clk (clk),
        .rstd(rstd),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.ins = (halt_plant && bus.pc == 32'd5) ? HALT : 32'd100 + bus.pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (halt_plant && a == 32'd5) ? HALT : 32'd100 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Reference model: state advances on each edge from the rules for queue, pc and mode.
    always @(posedge clk) begin
        int   sz;
        bit   pop;
        ent_t e;
        if (rstd) begin
            m_q.delete();
            m_pc   = 32'd0;
            m_busy = 1'b0;
            m_halt = 1'b0;
        end else begin
            sz  = m_q.size();
            pop = (sz != 0) && bus.out_ready;
            if (pop) void'(m_q.pop_front());
            if (bus.redirect) begin
                m_q.delete();
                m_pc   = bus.redirect_pc % 256;
                m_halt = 1'b0;
            end else begin
                if (m_busy && !m_halt && (sz < 4 || pop)) begin
                    e.pc  = m_pc;
                    e.ins = mem_word(m_pc);
                    m_q.push_back(e);
                    if (HALT_EN && e.ins == HALT) m_halt = 1'b1;
                    else m_pc = (m_pc + 1) % 256;
                end
                if (!m_busy && bus.start) m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            bit v;
            v = (m_q.size() != 0);
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, v});
            chk("out_pc",  bus.out_pc,  v ? m_q[0].pc  : 32'd0);
            chk("out_ins", bus.out_ins, v ? m_q[0].ins : 32'd0);
            chk("pc", bus.pc, m_pc);
            chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
            if (!rstd && bus.out_valid && bus.out_ready) begin
                log_pc.push_back(bus.out_pc);
                log_ins.push_back(bus.out_ins);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_log();
        log_pc.delete();
        log_ins.delete();
    endtask

    task automatic do_reset();
        rstd = 1'b1;
        cyc(2);
        rstd = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] pc_e, input logic [31:0] ins_e);
        if (idx < log_pc.size()) begin
            chk({name, "_pc"}, log_pc[idx], pc_e);
            chk({name, "_ins"}, log_ins[idx], ins_e);
        end else begin
            chk({name, "_count"}, log_pc.size(), idx + 1);
        end
    endtask

    initial begin
        rstd            = 1'b1;
        bus.start       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        cyc(2);
        checking = 1'b1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);

        // 1: start latency and streaming
        rstd = 1'b0;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("t1_valid_k", {31'd0, bus.out_valid}, 32'd0);
        clear_log();
        cyc(1);
        chk("t1_valid_k1", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_head_pc", bus.out_pc, 32'd0);
        chk("t1_head_ins", bus.out_ins, 32'd100);
        cyc(8);
        for (int i = 0; i < 6; i++) chk_log("t1", i, i, 100 + i);

        // 2: backpressure fills the queue and holds pc
        do_reset();
        bus.start = 1'b1;
        bus.out_ready = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        cyc(10);
        chk("t2_pc_hold", bus.pc, 32'd4);
        chk("t2_head_pc", bus.out_pc, 32'd0);
        clear_log();
        bus.out_ready = 1'b1;
        cyc(7);
        for (int i = 0; i < 6; i++) chk_log("t2", i, i, 100 + i);

        // 3: redirect near the top of the address space wraps
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd254;
        cyc(1);
        bus.redirect = 1'b0;
        clear_log();
        cyc(6);
        chk_log("t3a", 0, 254, 354);
        chk_log("t3b", 1, 255, 355);
        chk_log("t3c", 2, 0, 100);
        chk_log("t3d", 3, 1, 101);

        // 4: redirect flushes stale entries
        do_reset();
        bus.start = 1'b1;
        bus.out_ready = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        cyc(3);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_1F10;
        cyc(1);
        bus.redirect = 1'b0;
        chk("t4_flushed", {31'd0, bus.out_valid}, 32'd0);
        clear_log();
        bus.out_ready = 1'b1;
        cyc(4);
        chk_log("t4", 0, 32'h10, 116);

        // 5: reset mid-run, then restart
        cyc(3);
        rstd = 1'b1;
        cyc(1);
        rstd = 1'b0;
        chk("t5_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t5_pc", bus.pc, 32'd0);
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        clear_log();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(4);
        chk_log("t5", 0, 0, 100);

        // 6: halt word at address 5
        halt_plant = 1'b1;
        do_reset();
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        clear_log();
        cyc(15);
        chk_log("t6_w5", 5, 5, HALT);
        if (HALT_EN) begin
            chk("t6_len", log_pc.size(), 32'd6);
            chk("t6_halted", {31'd0, bus.halted}, 32'd1);
            chk("t6_pc", bus.pc, 32'd5);
            bus.redirect = 1'b1;
            bus.redirect_pc = 32'd0;
            cyc(1);
            bus.redirect = 1'b0;
            chk("t6_unhalt", {31'd0, bus.halted}, 32'd0);
            clear_log();
            cyc(4);
            chk_log("t6_resume", 0, 0, 100);
        end else begin
            chk_log("t6_w6", 6, 6, 106);
            chk("t6_halted", {31'd0, bus.halted}, 32'd0);
        end
        halt_plant = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rstd            = ($urandom_range(0, 99) == 0);
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = $urandom;
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) halt_plant = ~halt_plant;
            cyc(1);
        end
        rstd = 1'b0;
        bus.start = 1'b0;
        bus.redirect = 1'b0;
        cyc(2);
        checking = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
